// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and timing defaults.
// Used by the init, auto-refresh and arbiter stages.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;

   localparam logic [1:0]  BANK_NOP = 2'b11;
   localparam logic [12:0] ADDR_NOP = 13'h1fff;

   localparam int T_RP    = 2;
   localparam int T_RFC   = 7;
   localparam int T_MRD   = 3;
   localparam int CNT_REF = 750;
   localparam int AR_CNT  = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_TRP,
      S_AR,
      S_TRFC,
      S_END
   } aref_state_t;

endpackage

// File: rtl/sdram_aref_if.sv
// Request/grant and command bus between the refresh stage and the arbiter.
// master = refresh generator, slave = arbiter side.
interface sdram_aref_if;
   import sdram_pkg::*;

   logic        init_end;
   logic        aref_en;
   logic        aref_req;
   logic        aref_end;
   logic [3:0]  aref_cmd;
   logic [1:0]  aref_bank;
   logic [12:0] aref_addr;

   modport master (
      input  init_end,
      input  aref_en,
      output aref_req,
      output aref_end,
      output aref_cmd,
      output aref_bank,
      output aref_addr
   );

   modport slave (
      output init_end,
      output aref_en,
      input  aref_req,
      input  aref_end,
      input  aref_cmd,
      input  aref_bank,
      input  aref_addr
   );

endinterface

// File: rtl/sdram_aref.sv
// Periodic auto-refresh generator: interval timer, request flag and
// precharge-all / auto-refresh command sequencer.
module sdram_aref
   import sdram_pkg::*;
#(
   parameter int CNT_REF_MAX = CNT_REF,
   parameter int TRP         = T_RP,
   parameter int TRFC        = T_RFC,
   parameter int AR_NUM      = AR_CNT
) (
   input logic          aref_clk,
   input logic          aref_rst_n,
   sdram_aref_if.master bus
);

   localparam int RW   = $clog2(CNT_REF_MAX);
   localparam int TMAX = (TRP > TRFC) ? TRP : TRFC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int CW   = (TW > 4) ? TW : 4;

   logic [RW-1:0] ref_cnt_q, ref_cnt_d;
   logic          req_q, req_d;
   logic          wrap;
   logic          grant;

   aref_state_t   state_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    ar_q;
   logic [3:0]    cmd_q;
   logic          end_q;

   assign wrap  = (ref_cnt_q == RW'(CNT_REF_MAX - 1));
   assign grant = (state_q == S_IDLE) && req_q && bus.aref_en;

   // A fresh expiry outranks a same-edge grant so no interval is lost.
   always_comb begin
      ref_cnt_d = ref_cnt_q + RW'(1);
      req_d     = req_q;
      if (!bus.init_end) begin
         ref_cnt_d = '0;
         req_d     = 1'b0;
      end else begin
         if (wrap) ref_cnt_d = '0;
         if (wrap) req_d = 1'b1;
         else if (grant) req_d = 1'b0;
      end
   end

   always_ff @(posedge aref_clk) begin
      if (!aref_rst_n) begin
         ref_cnt_q <= '0;
         req_q     <= 1'b0;
      end else begin
         ref_cnt_q <= ref_cnt_d;
         req_q     <= req_d;
      end
   end

   always_ff @(posedge aref_clk) begin
      if (!aref_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ar_q    <= '0;
         cmd_q   <= CMD_NOP;
         end_q   <= 1'b0;
      end else begin
         cmd_q <= CMD_NOP;
         end_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               ar_q <= '0;
               if (grant) state_q <= S_PRE;
            end
            S_PRE: begin
               cmd_q   <= CMD_PRE;
               cnt_q   <= '0;
               state_q <= S_TRP;
            end
            S_TRP: begin
               if (cnt_q == CW'(TRP - 1)) begin
                  cnt_q   <= '0;
                  state_q <= S_AR;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_AR: begin
               cmd_q   <= CMD_AR;
               cnt_q   <= '0;
               ar_q    <= ar_q + 4'd1;
               state_q <= S_TRFC;
            end
            S_TRFC: begin
               if (cnt_q == CW'(TRFC - 1)) begin
                  cnt_q   <= '0;
                  state_q <= (ar_q < 4'(AR_NUM)) ? S_AR : S_END;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_END: begin
               end_q   <= 1'b1;
               ar_q    <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               cnt_q   <= '0;
               ar_q    <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.aref_req  = req_q;
   assign bus.aref_end  = end_q;
   assign bus.aref_cmd  = cmd_q;
   assign bus.aref_bank = BANK_NOP;
   assign bus.aref_addr = ADDR_NOP;

endmodule

// File: tb/tb_sdram_aref.sv
// Scoreboard bench for sdram_aref: expected command traces are queued
// at each accepted grant and popped one entry per clock edge.
module tb_sdram_aref;
   import sdram_pkg::*;

   localparam int RMAX = 20;
   localparam int P_RP = 2;
   localparam int P_RFC = 3;
   localparam int P_AR = 2;
   localparam int SEQ = 2 + P_RP + P_AR * (1 + P_RFC);

   typedef struct {
      logic [3:0] cmd;
      logic       fin;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   sdram_aref_if bus ();

   sdram_aref #(
      .CNT_REF_MAX(RMAX),
      .TRP(P_RP),
      .TRFC(P_RFC),
      .AR_NUM(P_AR)
   ) dut (
      .aref_clk(clk),
      .aref_rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   exp_t ex;
   int   hi;
   int   busy;
   logic mreq;
   int   n_chk;
   int   n_fail;

   // Advance one edge, update the reference model, then settle.
   task automatic tick();
      exp_t x;
      logic g;
      @(posedge clk);
      g = rst_n && (busy == 0) && mreq && bus.aref_en;
      if (!rst_n) begin
         busy = 0;
         q.delete();
      end else if (g) begin
         busy = SEQ;
         for (int k = 0; k <= SEQ; k++) begin
            x.cmd = CMD_NOP;
            x.fin = (k == SEQ);
            if (k == 1) x.cmd = CMD_PRE;
            for (int j = 0; j < P_AR; j++)
               if (k == 2 + P_RP + j * (1 + P_RFC)) x.cmd = CMD_AR;
            q.push_back(x);
         end
      end else if (busy > 0) begin
         busy--;
      end
      if (!rst_n || !bus.init_end) begin
         hi = 0;
         mreq = 1'b0;
      end else begin
         hi++;
         if (g) mreq = 1'b0;
         if (hi % RMAX == 0) mreq = 1'b1;
      end
      #1;
      if (q.size() > 0) ex = q.pop_front();
      else ex = '{CMD_NOP, 1'b0};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.init_end = 1'b0;
      bus.aref_en = 1'b0;
      for (int i = 0; i < 103; i++) begin
         if (i == 3) rst_n = 1'b1;
         tick();
         n_chk++;
         if (bus.aref_req !== 1'b0 || bus.aref_end !== 1'b0 ||
             bus.aref_cmd !== 4'b0111 || bus.aref_bank !== 2'b11 ||
             bus.aref_addr !== 13'h1fff) begin
            n_fail++;
            $display("FAIL reset i=%0d req=%b end=%b cmd=%b bank=%b addr=%h want 0 0 0111 11 1fff",
                     i, bus.aref_req, bus.aref_end, bus.aref_cmd,
                     bus.aref_bank, bus.aref_addr);
         end
      end
   endtask

   task automatic test_interval();
      bus.init_end = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         tick();
         n_chk++;
         if (bus.aref_req !== (k >= RMAX) || bus.aref_cmd !== CMD_NOP) begin
            n_fail++;
            $display("FAIL interval edge=%0d req=%b cmd=%b want req=%b cmd=0111",
                     k, bus.aref_req, bus.aref_cmd, k >= RMAX);
         end
      end
   endtask

   task automatic test_grant();
      bus.aref_en = 1'b1;
      for (int k = 0; k <= SEQ + 2; k++) begin
         tick();
         bus.aref_en = 1'b0;
         n_chk++;
         if (bus.aref_req !== mreq || bus.aref_end !== ex.fin ||
             bus.aref_cmd !== ex.cmd || bus.aref_bank !== BANK_NOP ||
             bus.aref_addr !== ADDR_NOP) begin
            n_fail++;
            $display("FAIL grant e+%0d req=%b end=%b cmd=%b want req=%b end=%b cmd=%b",
                     k, bus.aref_req, bus.aref_end, bus.aref_cmd,
                     mreq, ex.fin, ex.cmd);
         end
      end
   endtask

   task automatic test_spurious_en();
      bus.init_end = 1'b0;
      tick();
      bus.init_end = 1'b1;
      for (int k = 0; k < 60; k++) begin
         bus.aref_en = (k < 5) || (k == 20) || (k == 26) || (k == 27);
         tick();
         n_chk++;
         if (bus.aref_req !== mreq || bus.aref_end !== ex.fin ||
             bus.aref_cmd !== ex.cmd || bus.aref_bank !== BANK_NOP ||
             bus.aref_addr !== ADDR_NOP) begin
            n_fail++;
            $display("FAIL spurious_en k=%0d req=%b end=%b cmd=%b want req=%b end=%b cmd=%b",
                     k, bus.aref_req, bus.aref_end, bus.aref_cmd,
                     mreq, ex.fin, ex.cmd);
         end
      end
      bus.aref_en = 1'b0;
   endtask

   task automatic test_expiry_in_trfc();
      int found;
      int ars;
      found = 0;
      ars = 0;
      for (int k = 0; k < 45 && found == 0; k++) begin
         tick();
         if (mreq && (hi % RMAX == 0)) found = 1;
      end
      n_chk++;
      if (found == 0) begin
         n_fail++;
         $display("FAIL expiry_wait req=%b want expiry within 45 edges",
                  bus.aref_req);
      end
      for (int k = 0; k < 10 + 2 * (SEQ + 1); k++) begin
         bus.aref_en = (k == 10) || (k == 10 + SEQ + 1);
         tick();
         bus.aref_en = 1'b0;
         if (k > 10 + SEQ && bus.aref_cmd === CMD_AR) ars++;
         n_chk++;
         if (bus.aref_req !== mreq || bus.aref_end !== ex.fin ||
             bus.aref_cmd !== ex.cmd || bus.aref_bank !== BANK_NOP ||
             bus.aref_addr !== ADDR_NOP) begin
            n_fail++;
            $display("FAIL expiry_trfc k=%0d req=%b end=%b cmd=%b want req=%b end=%b cmd=%b",
                     k, bus.aref_req, bus.aref_end, bus.aref_cmd,
                     mreq, ex.fin, ex.cmd);
         end
      end
      n_chk++;
      if (ars != P_AR) begin
         n_fail++;
         $display("FAIL second_seq_ar_count got %0d want %0d", ars, P_AR);
      end
   endtask

   task automatic test_reset_mid_seq();
      for (int k = 0; k < 25 && !mreq; k++) tick();
      n_chk++;
      if (bus.aref_req !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_req_wait req=%b want 1", bus.aref_req);
      end
      bus.aref_en = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         if (k == 5) rst_n = 1'b0;
         tick();
         bus.aref_en = 1'b0;
         rst_n = 1'b1;
         n_chk++;
         if (bus.aref_req !== mreq || bus.aref_end !== ex.fin ||
             bus.aref_cmd !== ex.cmd || bus.aref_bank !== BANK_NOP ||
             bus.aref_addr !== ADDR_NOP ||
             (k == 25 && bus.aref_req !== 1'b1) ||
             (k == 24 && bus.aref_req !== 1'b0)) begin
            n_fail++;
            $display("FAIL reset_mid_seq e+%0d req=%b end=%b cmd=%b want req=%b end=%b cmd=%b",
                     k, bus.aref_req, bus.aref_end, bus.aref_cmd,
                     mreq, ex.fin, ex.cmd);
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      hi = 0;
      busy = 0;
      mreq = 1'b0;
      ex = '{CMD_NOP, 1'b0};
      bus.init_end = 1'b0;
      bus.aref_en = 1'b0;
      test_reset();
      test_interval();
      test_grant();
      test_spurious_en();
      test_expiry_in_trfc();
      test_reset_mid_seq();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
